// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha stream controller.
// Holds sigma constants, state word offsets and FSM encoding.
package chacha_pkg;

   localparam logic [31:0] SIGMA0 = 32'h61707865;
   localparam logic [31:0] SIGMA1 = 32'h3320646e;
   localparam logic [31:0] SIGMA2 = 32'h79622d32;
   localparam logic [31:0] SIGMA3 = 32'h6b206574;

   localparam logic [3:0] CONST_W = 4'd0;
   localparam logic [3:0] KEY_W   = 4'd4;
   localparam logic [3:0] CTR_W   = 4'd12;
   localparam logic [3:0] NONCE_W = 4'd13;

   localparam int unsigned BYTES_PER_BLOCK = 64;

   localparam logic [5:0] LAST_BYTE = 6'(BYTES_PER_BLOCK - 1);
   localparam logic [5:0] CTR_ADDR  = {CTR_W, 2'b00};
   localparam logic [5:0] CTR_LAST  = {CTR_W, 2'b11};

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_STREAM
   } state_e;

   function automatic logic [31:0] sigma_word(input logic [1:0] i);
      logic [31:0] w;
      w = SIGMA0;
      unique case (i)
         2'd0: w = SIGMA0;
         2'd1: w = SIGMA1;
         2'd2: w = SIGMA2;
         2'd3: w = SIGMA3;
         default: w = SIGMA0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/chacha_load_mux.sv
// Byte select of the ChaCha input state by 6-bit address.
// Words are little-endian: addr[5:2] word, addr[1:0] byte.
module chacha_load_mux
   import chacha_pkg::*;
(
   input  logic [5:0]   addr_i,
   input  logic [255:0] key_i,
   input  logic [95:0]  nonce_i,
   input  logic [31:0]  ctr_i,
   output logic [7:0]   byte_o
);

   logic [3:0]  w;
   logic [1:0]  cw;
   logic [2:0]  kw;
   logic [1:0]  nw;
   logic [31:0] word;

   assign w  = addr_i[5:2];
   assign cw = addr_i[3:2] - CONST_W[1:0];
   assign kw = addr_i[4:2] - KEY_W[2:0];
   assign nw = addr_i[3:2] - NONCE_W[1:0];

   // Pick the 32-bit state word that owns this address.
   always_comb begin
      word = 32'h0;
      unique case (1'b1)
         (w < KEY_W):
            word = sigma_word(cw);
         (w >= KEY_W) && (w < CTR_W):
            word = key_i[{kw, 5'b0} +: 32];
         (w == CTR_W):
            word = ctr_i;
         (w >= NONCE_W):
            word = nonce_i[{nw, 5'b0} +: 32];
         default:
            word = 32'h0;
      endcase
   end

   assign byte_o = word[{addr_i[1:0], 3'b0} +: 8];

endmodule

// File: rtl/chacha_stream_ctrl.sv
// Sequencer that loads the ChaCha core, waits for it, and
// streams keystream bytes out over a valid/ready interface.
module chacha_stream_ctrl
   import chacha_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] key,
   input  logic [95:0]  nonce,
   input  logic [31:0]  counter_init,
   input  logic [15:0]  num_blocks,
   output logic         busy,
   output logic         done,
   output logic [7:0]   ks_data,
   output logic         ks_valid,
   input  logic         ks_ready,
   output logic [5:0]   blk_addr,
   output logic [7:0]   blk_wdata,
   output logic         blk_write,
   input  logic [7:0]   blk_rdata,
   input  logic         blk_ready
);

   state_e         state_q, state_d;
   logic [5:0]     idx_q, idx_d;
   logic           full_q, full_d;
   logic           first_q, first_d;
   logic [15:0]    remain_q, remain_d;
   logic [31:0]    ctr_q, ctr_d;
   logic [255:0]   key_q, key_d;
   logic [95:0]    nonce_q, nonce_d;
   logic           done_q, done_d;
   logic [7:0]     load_byte;
   logic           load_last;

   chacha_load_mux u_mux (
      .addr_i  (idx_q),
      .key_i   (key_q),
      .nonce_i (nonce_q),
      .ctr_i   (ctr_q),
      .byte_o  (load_byte)
   );

   // Full load ends at byte 63; counter refresh ends at byte 51.
   assign load_last = full_q ? (idx_q == LAST_BYTE)
                             : (idx_q == CTR_LAST);

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         full_q   <= 1'b0;
         first_q  <= 1'b0;
         remain_q <= '0;
         ctr_q    <= '0;
         key_q    <= '0;
         nonce_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         full_q   <= full_d;
         first_q  <= first_d;
         remain_q <= remain_d;
         ctr_q    <= ctr_d;
         key_q    <= key_d;
         nonce_q  <= nonce_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic and bus outputs for the sequencer.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      full_d    = full_q;
      first_d   = first_q;
      remain_d  = remain_q;
      ctr_d     = ctr_q;
      key_d     = key_q;
      nonce_d   = nonce_q;
      done_d    = 1'b0;
      busy      = (state_q != S_IDLE);
      done      = done_q;
      ks_data   = blk_rdata;
      ks_valid  = 1'b0;
      blk_addr  = '0;
      blk_wdata = '0;
      blk_write = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               key_d    = key;
               nonce_d  = nonce;
               ctr_d    = counter_init;
               remain_d = num_blocks;
               idx_d    = '0;
               full_d   = 1'b1;
               if (num_blocks == 16'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end

         S_LOAD: begin
            blk_write = 1'b1;
            blk_addr  = idx_q;
            blk_wdata = load_byte;
            idx_d     = idx_q + 6'd1;
            if (load_last) begin
               state_d = S_WAIT;
               first_d = 1'b1;
               idx_d   = '0;
            end
         end

         // The core's ready is stale right after a write.
         S_WAIT: begin
            first_d = 1'b0;
            if (!first_q && blk_ready) begin
               state_d = S_STREAM;
               idx_d   = '0;
            end
         end

         S_STREAM: begin
            ks_valid = 1'b1;
            blk_addr = idx_q;
            if (ks_ready) begin
               idx_d = idx_q + 6'd1;
               if (idx_q == LAST_BYTE) begin
                  remain_d = remain_q - 16'd1;
                  ctr_d    = ctr_q + 32'd1;
                  if (remain_q == 16'd1) begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_LOAD;
                     full_d  = 1'b0;
                     idx_d   = CTR_ADDR;
                  end
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Bench for chacha_stream_ctrl with a behavioural ChaCha core.
// Output bytes are scored against a ChaCha20 reference model.
module tb_chacha_stream_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [255:0] key;
   logic [95:0]  nonce;
   logic [31:0]  counter_init;
   logic [15:0]  num_blocks;
   logic         busy;
   logic         done;
   logic [7:0]   ks_data;
   logic         ks_valid;
   logic         ks_ready = 1'b1;
   logic [5:0]   blk_addr;
   logic [7:0]   blk_wdata;
   logic         blk_write;
   logic [7:0]   blk_rdata;
   logic         blk_ready;

   always #5 clk = ~clk;

   chacha_stream_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .key          (key),
      .nonce        (nonce),
      .counter_init (counter_init),
      .num_blocks   (num_blocks),
      .busy         (busy),
      .done         (done),
      .ks_data      (ks_data),
      .ks_valid     (ks_valid),
      .ks_ready     (ks_ready),
      .blk_addr     (blk_addr),
      .blk_wdata    (blk_wdata),
      .blk_write    (blk_write),
      .blk_rdata    (blk_rdata),
      .blk_ready    (blk_ready)
   );

   function automatic logic [127:0] qr(
      input logic [31:0] ai, bi, ci, di);
      logic [31:0] a, b, c, d;
      a = ai; b = bi; c = ci; d = di;
      a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
      c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
      a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
      c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
      return {a, b, c, d};
   endfunction

   function automatic logic [511:0] cc_block(input logic [511:0] s);
      logic [31:0]  x [16];
      logic [511:0] r;
      for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
      for (int n = 0; n < 10; n++) begin
         {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
         {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
         {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
         {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
         {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
         {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
         {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
         {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
      end
      for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[32*i +: 32];
      return r;
   endfunction

   function automatic logic [511:0] mk_state(
      input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
      return {n, c, k, 32'h6b206574, 32'h79622d32,
              32'h3320646e, 32'h61707865};
   endfunction

   // Behavioural core: ready is briefly stale-high after a write.
   bit [511:0] cst;
   bit [511:0] cout;
   int         bcnt = 0;
   bit         stale = 1'b0;

   always @(posedge clk) begin
      stale <= blk_write;
      if (blk_write) begin
         cst[{blk_addr, 3'b0} +: 8] <= blk_wdata;
         bcnt <= 4;
      end else if (bcnt > 0) begin
         bcnt <= bcnt - 1;
         if (bcnt == 1) cout <= cc_block(cst);
      end
   end

   assign blk_ready = (bcnt == 0) || stale;
   assign blk_rdata = cout[{blk_addr, 3'b0} +: 8];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [7:0] exp_q [$];
   logic [7:0] rx_q [$];
   logic [7:0] ref_q [$];
   logic [7:0] ctr_log [$];
   int  wr_cnt = 0;
   int  hs_cnt = 0;
   int  done_cnt = 0;
   int  cyc = 0;
   int  last_hs = 0;
   bit  hs_since = 0;
   bit  rnd = 0;
   bit  rst_s = 0;

   always @(posedge clk) rst_s <= rst;

   // Monitor: drives ks_ready, scores bytes, counts writes/done.
   initial begin : monitor
      bit         stall_q;
      logic [7:0] stall_d;
      logic [7:0] e;
      stall_q = 0;
      stall_d = '0;
      forever begin
         @(negedge clk);
         cyc++;
         ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stall_q && !rst_s) begin
            chk("stall_valid", ks_valid, 1);
            chk("stall_data", ks_data, stall_d);
         end
         stall_q = ks_valid && !ks_ready;
         stall_d = ks_data;
         if (ks_valid && ks_ready) begin
            if (exp_q.size() == 0) begin
               chk("extra_byte", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("ks_data", ks_data, e);
            end
            rx_q.push_back(ks_data);
            hs_cnt++;
            last_hs = cyc;
            hs_since = 1;
         end
         if (blk_write) begin
            wr_cnt++;
            if (blk_addr >= 6'd48 && blk_addr < 6'd52)
               ctr_log.push_back(blk_wdata);
         end
         if (done) begin
            done_cnt++;
            if (hs_since) chk("done_timing", cyc, last_hs + 1);
            chk("busy_at_done", busy, 0);
            hs_since = 0;
         end
      end
   end

   typedef struct {
      logic [255:0] key;
      logic [95:0]  nonce;
      logic [31:0]  ctr;
      logic [15:0]  nblk;
      bit           rnd;
      int           exp_wr;
   } vec_t;

   vec_t vt [4];

   task automatic push_exp(input logic [255:0] k,
                           input logic [95:0] n,
                           input logic [31:0] c,
                           input int nb);
      logic [511:0] blk;
      for (int b = 0; b < nb; b++) begin
         blk = cc_block(mk_state(k, n, c + 32'(b)));
         for (int i = 0; i < 64; i++) exp_q.push_back(blk[8*i +: 8]);
      end
   endtask

   task automatic begin_run(input vec_t v);
      rnd = v.rnd;
      wr_cnt = 0; hs_cnt = 0; done_cnt = 0;
      ctr_log.delete(); rx_q.delete();
      push_exp(v.key, v.nonce, v.ctr, int'(v.nblk));
      key = v.key; nonce = v.nonce;
      counter_init = v.ctr; num_blocks = v.nblk;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("first_write", {blk_write, blk_addr}, {1'b1, 6'd0});
   endtask

   task automatic wait_done(input int n, input int lim);
      int k;
      k = 0;
      while (done_cnt < n && k < lim) begin
         @(negedge clk);
         k++;
      end
      if (done_cnt < n) chk("done_timeout", done_cnt, n);
   endtask

   task automatic run_vec(input vec_t v);
      logic [31:0] c;
      begin_run(v);
      wait_done(1, int'(v.nblk) * 400 + 200);
      repeat (3) @(negedge clk);
      chk("done_count", done_cnt, 1);
      chk("byte_count", hs_cnt, int'(v.nblk) * 64);
      chk("write_count", wr_cnt, v.exp_wr);
      chk("leftover", exp_q.size(), 0);
      chk("ctr_log_len", ctr_log.size(), int'(v.nblk) * 4);
      if (ctr_log.size() == int'(v.nblk) * 4) begin
         for (int b = 0; b < int'(v.nblk); b++) begin
            c = v.ctr + 32'(b);
            for (int j = 0; j < 4; j++)
               chk("ctr_byte", ctr_log[4*b + j], c[8*j +: 8]);
         end
      end
   endtask

   task automatic do_reset(input string tag);
      int w;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_valid"}, ks_valid, 0);
      chk({tag, "_write"}, blk_write, 0);
      chk({tag, "_addr"}, blk_addr, 0);
      chk({tag, "_wdata"}, blk_wdata, 0);
      chk({tag, "_done"}, done, 0);
      exp_q.delete();
      w = wr_cnt;
      repeat (3) @(negedge clk);
      chk({tag, "_no_writes"}, wr_cnt, w);
      chk({tag, "_no_valid"}, ks_valid, 0);
      hs_since = 0;
   endtask

   initial begin : main
      logic [7:0] rfc [8];
      vec_t v;
      int k;
      rfc = '{8'h10, 8'hf1, 8'he7, 8'he4, 8'hd1, 8'h3b, 8'h59, 8'h15};

      vt[0] = '{256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100,
                96'h00000000_4a000000_09000000, 32'd1, 16'd1, 1'b0, 64};
      vt[1] = '{256'hdeadbeef_01234567_89abcdef_cafef00d_0badc0de_13579bdf_2468ace0_5a5aa5a5,
                96'h11223344_55667788_99aabbcc, 32'hfffffffe, 16'd3, 1'b0, 72};
      vt[2] = '{256'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_00ff00ff_a0b0c0d0_12121212_feedface,
                96'h000000aa_000000bb_000000cc, 32'd7, 16'd2, 1'b0, 68};
      vt[3] = vt[2];
      vt[3].rnd = 1'b1;

      rst = 1'b1; start = 1'b0;
      key = '0; nonce = '0; counter_init = '0; num_blocks = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", ks_valid, 0);
      chk("rst_write", blk_write, 0);
      chk("rst_addr", blk_addr, 0);
      chk("rst_wdata", blk_wdata, 0);
      rst = 1'b0;
      @(negedge clk);

      // Zero-block request.
      wr_cnt = 0; hs_cnt = 0;
      num_blocks = 16'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_write", blk_write, 0);
      @(negedge clk);
      chk("zero_done_pulse", done, 0);
      for (int i = 0; i < 3; i++) begin
         chk("zero_valid", ks_valid, 0);
         @(negedge clk);
      end
      chk("zero_writes", wr_cnt, 0);
      chk("zero_bytes", hs_cnt, 0);

      // Table-driven runs.
      for (int i = 0; i < 4; i++) begin
         run_vec(vt[i]);
         if (i == 0 && rx_q.size() >= 8) begin
            for (int j = 0; j < 8; j++) chk("rfc_byte", rx_q[j], rfc[j]);
         end
         if (i == 2) ref_q = rx_q;
         if (i == 3) begin
            chk("rnd_len", rx_q.size(), ref_q.size());
            if (rx_q.size() == ref_q.size())
               for (int j = 0; j < rx_q.size(); j++)
                  chk("rnd_vs_full", rx_q[j], ref_q[j]);
         end
         @(negedge clk);
      end

      // Reset while waiting on the core.
      v = vt[1];
      v.nblk = 16'd1;
      v.exp_wr = 64;
      begin_run(v);
      k = 0;
      while (!(busy && !blk_write && !ks_valid) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("reach_wait", busy && !blk_write && !ks_valid, 1);
      do_reset("rst_wait");
      run_vec(v);

      // Reset partway through streaming.
      begin_run(v);
      k = 0;
      while (hs_cnt < 20 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("reach_byte20", hs_cnt >= 20, 1);
      do_reset("rst_stream");
      run_vec(v);

      // Start held high across a run.
      rnd = 0; wr_cnt = 0; hs_cnt = 0; done_cnt = 0;
      push_exp(vt[0].key, vt[0].nonce, 32'd5, 1);
      key = vt[0].key; nonce = vt[0].nonce;
      counter_init = 32'd5; num_blocks = 16'd1;
      start = 1'b1;
      @(negedge clk);
      key = vt[1].key; nonce = vt[1].nonce;
      counter_init = 32'd9;
      wait_done(1, 600);
      push_exp(vt[1].key, vt[1].nonce, 32'd9, 1);
      @(negedge clk);
      start = 1'b0;
      chk("restart_busy", busy, 1);
      wait_done(2, 600);
      repeat (3) @(negedge clk);
      chk("held_done_count", done_cnt, 2);
      chk("held_writes", wr_cnt, 128);
      chk("held_bytes", hs_cnt, 128);
      chk("held_leftover", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
